dest_ip_tbl_arbiter: RTL and testbench

//  Shares the single read/write port of the 32-entry destination-IP table between two requesters:
//  - A: AXI-Lite register path.
//  - B: CPU-side table maintenance path.

---
 rtl/dest_ip_tbl_arbiter_if.sv | 53 +++++
 rtl/dest_ip_tbl_arbiter.sv | 158 +++++++++++++++
 tb/tb_dest_ip_tbl_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dest_ip_tbl_arbiter_if.sv
// Requester A/B command ports and destination-IP table port,
// grouped for the round-robin table arbiter.
interface dest_ip_tbl_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          a_req;
  logic          a_wr;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ack;
  logic          a_err;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_wr;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ack;
  logic          b_err;
  logic [DW-1:0] b_rdata;

  logic          tbl_rd_req;
  logic          tbl_wr_req;
  logic [AW-1:0] tbl_rd_addr;
  logic [AW-1:0] tbl_wr_addr;
  logic [DW-1:0] tbl_wr_data;
  logic [DW-1:0] tbl_rd_data;
  logic          tbl_rd_ack;
  logic          tbl_wr_ack;

  modport master (
    input  a_req, a_wr, a_addr, a_wdata,
    output a_ack, a_err, a_rdata,
    input  b_req, b_wr, b_addr, b_wdata,
    output b_ack, b_err, b_rdata,
    output tbl_rd_req, tbl_wr_req,
    output tbl_rd_addr, tbl_wr_addr,
    output tbl_wr_data,
    input  tbl_rd_data, tbl_rd_ack, tbl_wr_ack
  );

  modport slave (
    output a_req, a_wr, a_addr, a_wdata,
    input  a_ack, a_err, a_rdata,
    output b_req, b_wr, b_addr, b_wdata,
    input  b_ack, b_err, b_rdata,
    input  tbl_rd_req, tbl_wr_req,
    input  tbl_rd_addr, tbl_wr_addr,
    input  tbl_wr_data,
    output tbl_rd_data, tbl_rd_ack, tbl_wr_ack
  );
endinterface

// File: rtl/dest_ip_tbl_arbiter.sv
// Round-robin arbiter sharing the destination-IP table port
// between the AXI-Lite register path (A) and the CPU path (B).
module dest_ip_tbl_arbiter #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int TBL_ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES     = 16
) (
  input  logic                          AXI_ACLK,
  input  logic                          reset,
  dest_ip_tbl_arbiter_if.master         bus,
  output logic [C_S_AXI_DATA_WIDTH-1:0] timeout_count
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = TBL_ADDR_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] TMO_MAX = '1;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic          grant_q, grant_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          rd_req_q, rd_req_d;
  logic          wr_req_q, wr_req_d;
  logic          a_ack_q, a_ack_d;
  logic          a_err_q, a_err_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic          b_ack_q, b_ack_d;
  logic          b_err_q, b_err_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic [DW-1:0] tmo_q, tmo_d;

  logic          pick;
  logic          hit;
  logic          expire;
  logic [DW-1:0] rdata_n;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rd_req_d  = 1'b0;
    wr_req_d  = 1'b0;
    a_ack_d   = 1'b0;
    a_err_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_ack_d   = 1'b0;
    b_err_d   = 1'b0;
    b_rdata_d = b_rdata_q;
    tmo_d     = tmo_q;

    // 1 selects B; on a tie the requester not served last wins
    pick = (bus.a_req && bus.b_req) ? ~last_q : bus.b_req;
    hit = wr_q ? bus.tbl_wr_ack : bus.tbl_rd_ack;
    expire = (cnt_q == CNT_LAST);
    rdata_n = (hit && !wr_q) ? bus.tbl_rd_data : '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.a_req || bus.b_req) begin
          grant_d  = pick;
          wr_d     = pick ? bus.b_wr : bus.a_wr;
          addr_d   = pick ? bus.b_addr : bus.a_addr;
          wdata_d  = pick ? bus.b_wdata : bus.a_wdata;
          wr_req_d = wr_d;
          rd_req_d = !wr_d;
          cnt_d    = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (hit || expire) begin
          state_d = S_DONE;
          if (grant_q) begin
            b_ack_d   = 1'b1;
            b_err_d   = !hit;
            b_rdata_d = rdata_n;
          end else begin
            a_ack_d   = 1'b1;
            a_err_d   = !hit;
            a_rdata_d = rdata_n;
          end
          if (!hit && tmo_q != TMO_MAX)
            tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (reset) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      grant_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      a_ack_q   <= 1'b0;
      a_err_q   <= 1'b0;
      a_rdata_q <= '0;
      b_ack_q   <= 1'b0;
      b_err_q   <= 1'b0;
      b_rdata_q <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rd_req_q  <= rd_req_d;
      wr_req_q  <= wr_req_d;
      a_ack_q   <= a_ack_d;
      a_err_q   <= a_err_d;
      a_rdata_q <= a_rdata_d;
      b_ack_q   <= b_ack_d;
      b_err_q   <= b_err_d;
      b_rdata_q <= b_rdata_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus.a_ack       = a_ack_q;
  assign bus.a_err       = a_err_q;
  assign bus.a_rdata     = a_rdata_q;
  assign bus.b_ack       = b_ack_q;
  assign bus.b_err       = b_err_q;
  assign bus.b_rdata     = b_rdata_q;
  assign bus.tbl_rd_req  = rd_req_q;
  assign bus.tbl_wr_req  = wr_req_q;
  assign bus.tbl_rd_addr = addr_q;
  assign bus.tbl_wr_addr = addr_q;
  assign bus.tbl_wr_data = wdata_q;
  assign timeout_count   = tmo_q;
endmodule

// File: tb/tb_dest_ip_tbl_arbiter.sv
// Scoreboard bench for dest_ip_tbl_arbiter with a behavioural
// table model whose ack behaviour is selectable per test.
module tb_dest_ip_tbl_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] timeout_count;

  always #5 clk = ~clk;

  dest_ip_tbl_arbiter_if bus ();

  dest_ip_tbl_arbiter dut (
    .AXI_ACLK      (clk),
    .reset         (reset),
    .bus           (bus),
    .timeout_count (timeout_count)
  );

  typedef struct {
    bit          who;
    bit          err;
    bit          chk_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          tmode = 0;
  logic [31:0] mem [32];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // table: 0 normal ack, 1 no ack, 2 rd_ack for writes only
  always @(posedge clk) begin
    bus.tbl_rd_ack <= 1'b0;
    bus.tbl_wr_ack <= 1'b0;
    if (bus.tbl_wr_req) begin
      mem[bus.tbl_wr_addr] <= bus.tbl_wr_data;
      if (tmode == 0) bus.tbl_wr_ack <= 1'b1;
      if (tmode == 2) bus.tbl_rd_ack <= 1'b1;
    end
    if (bus.tbl_rd_req) begin
      bus.tbl_rd_data <= mem[bus.tbl_rd_addr];
      if (tmode == 0) bus.tbl_rd_ack <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.tbl_rd_req && bus.tbl_wr_req)
        check("one_strobe", 32'd2, 32'd1);
      if (bus.a_ack || bus.b_ack) begin
        if (sb.size() == 0) begin
          check("sb_unexp_ack", {bus.a_ack, bus.b_ack}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_both", {bus.a_ack, bus.b_ack} == 2'b11, 0);
          check("grant_who", bus.b_ack, e.who);
          check("err", e.who ? bus.b_err : bus.a_err, e.err);
          if (e.chk_rd)
            check("rdata", e.who ? bus.b_rdata : bus.a_rdata,
                  e.rdata);
        end
      end
    end
  end

  task automatic set_req(input bit who, input bit v, input bit wr,
                         input logic [4:0] addr,
                         input logic [31:0] wd);
    if (who) begin
      bus.b_req = v; bus.b_wr = wr;
      bus.b_addr = addr; bus.b_wdata = wd;
    end else begin
      bus.a_req = v; bus.a_wr = wr;
      bus.a_addr = addr; bus.a_wdata = wd;
    end
  endtask

  // called at a negedge with the DUT idle; ends at a negedge
  task automatic do_txn(input bit who, input bit wr,
                        input logic [4:0] addr,
                        input logic [31:0] wd,
                        input bit push, input bit eerr,
                        input bit chk_rd,
                        input logic [31:0] erd,
                        output int lat, output int nrd,
                        output int nwr);
    exp_t e;
    bit   seen;
    if (push) begin
      e.who = who; e.err = eerr;
      e.chk_rd = chk_rd; e.rdata = erd;
      sb.push_back(e);
    end
    set_req(who, 1'b1, wr, addr, wd);
    lat = 0; nrd = 0; nwr = 0; seen = 0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      nrd += int'(bus.tbl_rd_req);
      nwr += int'(bus.tbl_wr_req);
      seen = who ? bus.b_ack : bus.a_ack;
    end
    if (!seen) check("ack_timeout", 0, 1);
    set_req(who, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int lat, nrd, nwr, l2, r2, w2;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    bus.tbl_rd_ack = 1'b0;
    bus.tbl_wr_ack = 1'b0;
    bus.tbl_rd_data = '0;
    set_req(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_strobes",
          {bus.tbl_rd_req, bus.tbl_wr_req,
           bus.a_ack, bus.a_err, bus.b_ack, bus.b_err}, 0);
    check("rst_tmo", timeout_count, 0);
    check("rst_addr", {bus.tbl_rd_addr, bus.tbl_wr_addr}, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: A write, 1-cycle table ack
    do_txn(0, 1, 5'd3, 32'h0A000001, 1, 0, 0, 0, lat, nrd, nwr);
    check("t1_lat", lat, 3);
    check("t1_wr_strobes", nwr, 1);
    check("t1_rd_strobes", nrd, 0);

    // 2: B read back
    do_txn(1, 0, 5'd3, 32'h0, 1, 0, 1, 32'h0A000001,
           lat, nrd, nwr);
    check("t2_lat", lat, 3);
    check("t2_rd_strobes", nrd, 1);
    check("t2_wr_strobes", nwr, 0);

    // 3: simultaneous requests, two each, expect A,B,A,B
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.who = i[0]; e.err = 0; e.chk_rd = 0; e.rdata = 0;
      sb.push_back(e);
    end
    fork
      begin
        do_txn(0, 1, 5'd10, 32'h11, 0, 0, 0, 0, lat, nrd, nwr);
        do_txn(0, 1, 5'd11, 32'h22, 0, 0, 0, 0, lat, nrd, nwr);
      end
      begin
        do_txn(1, 0, 5'd3, 0, 0, 0, 0, 0, l2, r2, w2);
        do_txn(1, 0, 5'd3, 0, 0, 0, 0, 0, l2, r2, w2);
      end
    join
    repeat (2) @(negedge clk);
    check("t3_sb_drained", sb.size(), 0);
    check("t3_mem10", mem[10], 32'h11);

    // 4: read timeout, no table ack
    tmode = 1;
    do_txn(0, 0, 5'd3, 0, 1, 1, 1, 32'h0, lat, nrd, nwr);
    check("t4_lat", lat, 18);
    check("t4_tmo", timeout_count, 1);

    // 6: write answered only by rd_ack
    tmode = 2;
    do_txn(0, 1, 5'd9, 32'h5, 1, 1, 0, 0, lat, nrd, nwr);
    check("t6_lat", lat, 18);
    check("t6_tmo", timeout_count, 2);

    // 5: reset during WAIT of a B write
    tmode = 1;
    set_req(1'b1, 1'b1, 1'b1, 5'd7, 32'hDEAD);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    set_req(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("t5_flags",
          {bus.tbl_rd_req, bus.tbl_wr_req,
           bus.a_ack, bus.a_err, bus.b_ack, bus.b_err}, 0);
    check("t5_addr", {bus.tbl_rd_addr, bus.tbl_wr_addr}, 0);
    check("t5_wdata", bus.tbl_wr_data, 0);
    check("t5_rdata_a", bus.a_rdata, 0);
    check("t5_tmo", timeout_count, 0);
    reset = 1'b0;
    tmode = 0;
    repeat (3) @(negedge clk);
    check("t5_no_back", bus.b_ack, 0);
    do_txn(0, 0, 5'd3, 0, 1, 0, 1, 32'h0A000001,
           lat, nrd, nwr);
    check("t5_after_lat", lat, 3);
    check("t5_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
